// File: rtl/m_74ls_pkg.sv
// m_74ls_pkg: shared direction constants and terminal-count helper for the 74LS counter family
package m_74ls_pkg;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  function automatic int tc_value(input int modulus, input logic dir);
    return (dir == DIR_DOWN) ? 0 : modulus - 1;
  endfunction
endpackage

// File: rtl/m_74ls_tc.sv
// m_74ls_tc: combinational terminal-count detector producing MAX_MIN and the cascade CO_BO
module m_74ls_tc
  import m_74ls_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             D_U,
  input  logic             CT,
  output logic             MAX_MIN,
  output logic             CO_BO
);
  localparam logic [WIDTH-1:0] TC_UP = WIDTH'(tc_value(MODULUS, DIR_UP));
  localparam logic [WIDTH-1:0] TC_DOWN = WIDTH'(tc_value(MODULUS, DIR_DOWN));
  // terminal value follows the current direction with no register in the path
  always_comb begin
    MAX_MIN = Q == (D_U ? TC_DOWN : TC_UP);
    CO_BO = MAX_MIN & ~CT;
  end
endmodule

// File: rtl/m_74ls191.sv
// m_74ls191: synchronous presettable up/down counter; define M_74LS191_WRAP_EN to add the sticky WRAP flag
module m_74ls191
  import m_74ls_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             LD,
  input  logic             CT,
  input  logic             D_U,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             MAX_MIN,
  output logic             CO_BO
`ifdef M_74LS191_WRAP_EN
  ,
  output logic             WRAP
`endif
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("m_74ls191: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end
  logic             wrap;
  logic [WIDTH-1:0] nxt;
  // out-of-range loaded values wrap to 0 going up and decrement normally going down
  always_comb begin
    wrap = (D_U == DIR_DOWN) ? (Q == '0) : (Q >= TOP);
    nxt = (D_U == DIR_DOWN) ? (wrap ? TOP : Q - 1'b1) : (wrap ? '0 : Q + 1'b1);
  end
  // priority: reset, load, count, hold
  always_ff @(posedge CP) begin
    if (CR) Q <= '0;
    else if (!LD) Q <= D;
    else if (!CT) Q <= nxt;
  end
`ifdef M_74LS191_WRAP_EN
  // sticky on any counting wrap; only reset clears it, loads leave it alone
  always_ff @(posedge CP) begin
    if (CR) WRAP <= 1'b0;
    else if (LD && !CT && wrap) WRAP <= 1'b1;
  end
`endif
  m_74ls_tc #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_tc (
    .Q(Q),
    .D_U(D_U),
    .CT(CT),
    .MAX_MIN(MAX_MIN),
    .CO_BO(CO_BO)
  );
endmodule

// File: tb/tb_m_74ls191.sv
// tb_m_74ls191: directed vector table plus decade, direction and cascade sequences
module tb_m_74ls191;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic a_cr, a_ld, a_ct, a_du, a_mm, a_co;
  logic [3:0] a_d, a_q;
  logic b_cr, b_ld, b_ct, b_du, b_mm, b_co;
  logic [3:0] b_d, b_q;
  logic c_cr, c_ld, c_du, c_mml, c_col, c_mmh, c_coh;
  logic [3:0] c_dl, c_dh, c_ql, c_qh;
`ifdef M_74LS191_WRAP_EN
  logic a_wrap, b_wrap, c_wl, c_wh;
`endif
  m_74ls191 #(.WIDTH(4), .MODULUS(16)) dut_a (
    .CP(clk), .CR(a_cr), .LD(a_ld), .CT(a_ct), .D_U(a_du), .D(a_d),
    .Q(a_q), .MAX_MIN(a_mm), .CO_BO(a_co)
`ifdef M_74LS191_WRAP_EN
    , .WRAP(a_wrap)
`endif
  );
  m_74ls191 #(.WIDTH(4), .MODULUS(10)) dut_b (
    .CP(clk), .CR(b_cr), .LD(b_ld), .CT(b_ct), .D_U(b_du), .D(b_d),
    .Q(b_q), .MAX_MIN(b_mm), .CO_BO(b_co)
`ifdef M_74LS191_WRAP_EN
    , .WRAP(b_wrap)
`endif
  );
  m_74ls191 #(.WIDTH(4), .MODULUS(16)) dut_lo (
    .CP(clk), .CR(c_cr), .LD(c_ld), .CT(1'b0), .D_U(c_du), .D(c_dl),
    .Q(c_ql), .MAX_MIN(c_mml), .CO_BO(c_col)
`ifdef M_74LS191_WRAP_EN
    , .WRAP(c_wl)
`endif
  );
  m_74ls191 #(.WIDTH(4), .MODULUS(16)) dut_hi (
    .CP(clk), .CR(c_cr), .LD(c_ld), .CT(~c_col), .D_U(c_du), .D(c_dh),
    .Q(c_qh), .MAX_MIN(c_mmh), .CO_BO(c_coh)
`ifdef M_74LS191_WRAP_EN
    , .WRAP(c_wh)
`endif
  );
  typedef struct {
    logic cr, ld, ct, du;
    logic [3:0] d, q;
    logic mm, co, wrap;
  } vec_t;
  vec_t v[18];
  function automatic vec_t mk(logic cr, logic ld, logic ct, logic du, logic [3:0] d,
                              logic [3:0] q, logic mm, logic co, logic wrap);
    vec_t r;
    r.cr = cr; r.ld = ld; r.ct = ct; r.du = du; r.d = d;
    r.q = q; r.mm = mm; r.co = co; r.wrap = wrap;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    v[0]  = mk(1, 0, 0, 0, 4'hC, 4'h0, 0, 0, 0);
    v[1]  = mk(0, 0, 1, 0, 4'hC, 4'hC, 0, 0, 0);
    v[2]  = mk(0, 0, 1, 1, 4'h2, 4'h2, 0, 0, 0);
    v[3]  = mk(0, 1, 0, 1, 4'h0, 4'h1, 0, 0, 0);
    v[4]  = mk(0, 1, 0, 1, 4'h0, 4'h0, 1, 1, 0);
    v[5]  = mk(0, 1, 0, 1, 4'h0, 4'hF, 0, 0, 1);
    v[6]  = mk(0, 1, 0, 1, 4'h0, 4'hE, 0, 0, 1);
    v[7]  = mk(0, 1, 1, 1, 4'h0, 4'hE, 0, 0, 1);
    v[8]  = mk(1, 0, 0, 1, 4'h7, 4'h0, 1, 1, 0);
    v[9]  = mk(0, 0, 0, 0, 4'h5, 4'h5, 0, 0, 0);
    v[10] = mk(0, 0, 1, 0, 4'hF, 4'hF, 1, 0, 0);
    v[11] = mk(0, 1, 0, 1, 4'h0, 4'hE, 0, 0, 0);
    v[12] = mk(0, 0, 1, 1, 4'h0, 4'h0, 1, 0, 0);
    v[13] = mk(0, 1, 0, 0, 4'h0, 4'h1, 0, 0, 0);
    v[14] = mk(0, 1, 0, 0, 4'h0, 4'h2, 0, 0, 0);
    v[15] = mk(0, 0, 1, 0, 4'hE, 4'hE, 0, 0, 0);
    v[16] = mk(0, 1, 0, 0, 4'h0, 4'hF, 1, 1, 0);
    v[17] = mk(0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1);
    a_cr = 1; a_ld = 1; a_ct = 1; a_du = 0; a_d = 0;
    b_cr = 1; b_ld = 1; b_ct = 1; b_du = 0; b_d = 0;
    c_cr = 1; c_ld = 1; c_du = 1; c_dl = 0; c_dh = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) begin
      a_cr = v[i].cr; a_ld = v[i].ld; a_ct = v[i].ct; a_du = v[i].du; a_d = v[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d q", i), 32'(a_q), 32'(v[i].q));
      chk($sformatf("vec%0d max_min", i), 32'(a_mm), 32'(v[i].mm));
      chk($sformatf("vec%0d co_bo", i), 32'(a_co), 32'(v[i].co));
`ifdef M_74LS191_WRAP_EN
      chk($sformatf("vec%0d wrap", i), 32'(a_wrap), 32'(v[i].wrap));
`endif
    end
    a_ct = 1; a_du = 1;
    #1;
    chk("flip max_min down at 0", 32'(a_mm), 32'd1);
    a_du = 0;
    #1;
    chk("flip max_min up at 0", 32'(a_mm), 32'd0);
    b_cr = 0; b_ct = 0; b_du = 0;
    #1;
    chk("dec reset q", 32'(b_q), 32'd0);
    chk("dec reset co", 32'(b_co), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("dec step%0d q", i), 32'(b_q), 32'(i % 10));
      chk($sformatf("dec step%0d co", i), 32'(b_co), 32'((i % 10) == 9));
    end
    b_cr = 1;
    @(posedge clk);
    #1;
    b_cr = 0; b_ld = 0; b_d = 4'hC;
    @(posedge clk);
    #1;
    chk("dec load C q", 32'(b_q), 32'hC);
    chk("dec load C max_min", 32'(b_mm), 32'd0);
`ifdef M_74LS191_WRAP_EN
    chk("dec load wrap clear", 32'(b_wrap), 32'd0);
`endif
    b_ld = 1;
    @(posedge clk);
    #1;
    chk("dec out-of-range wrap q", 32'(b_q), 32'd0);
`ifdef M_74LS191_WRAP_EN
    chk("dec out-of-range wrap flag", 32'(b_wrap), 32'd1);
`endif
    c_cr = 0; c_ld = 0; c_dh = 4'h1; c_dl = 4'h0;
    @(posedge clk);
    #1;
    chk("casc load 10", 32'({c_qh, c_ql}), 32'h10);
    chk("casc lo co at 10", 32'(c_col), 32'd1);
    chk("casc hi co at 10", 32'(c_coh), 32'd0);
    c_ld = 1;
    @(posedge clk);
    #1;
    chk("casc 0F", 32'({c_qh, c_ql}), 32'h0F);
    @(posedge clk);
    #1;
    chk("casc 0E", 32'({c_qh, c_ql}), 32'h0E);
    c_ld = 0; c_dh = 0; c_dl = 0;
    @(posedge clk);
    #1;
    c_ld = 1;
    #1;
    chk("casc lo co at 00", 32'(c_col), 32'd1);
    chk("casc hi co at 00", 32'(c_coh), 32'd1);
    @(posedge clk);
    #1;
    chk("casc FF", 32'({c_qh, c_ql}), 32'hFF);
    chk("casc hi co at FF", 32'(c_coh), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
